periph_acc_cfg_arbiter: RTL and testbench
=========================================

PERIPH_ACC_CFG_ARBITER -- requirements
Module: periph_acc_cfg_arbiter

Interface
REQ-001 Parameter NB_HWPE, default 2, number of HWPE config targets (1..8).
REQ-002 Parameter ID_WIDTH, default 5, transaction id width.
REQ-003 Parameter SEL_LSB, default 10, LSB of target-select field in address (1 KiB window per HWPE).
REQ-004 Parameter TIMEOUT, default 255, max cycles per forwarded transaction before error (1..65535).
REQ-005 clk  in  1  sole clock, rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 s_req  in  1  speriph slave request; s_add in 32; s_wen in 1 (1=read); s_wdata in 32; s_be in 4; s_id in ID_WIDTH.
REQ-008 s_gnt  out  1  request accepted.
REQ-009 s_r_valid out 1; s_r_rdata out 32; s_r_opc out 1 (1=error); s_r_id out ID_WIDTH.
REQ-010 m_req out NB_HWPE; m_add out 32; m_wen out 1; m_wdata out 32; m_be out 4; m_id out ID_WIDTH (shared fields, per-target req).
REQ-011 m_gnt in NB_HWPE; m_r_valid in NB_HWPE; m_r_rdata in NB_HWPE*32; m_r_opc in NB_HWPE; m_r_id in NB_HWPE*ID_WIDTH.
REQ-012 err_cnt  out  8  saturating count of error responses.

Function
REQ-013 FSM states IDLE, ISSUE, WAIT_RSP, RESP, ERR; exactly one transaction outstanding.
REQ-014 IDLE: s_gnt = s_req (combinational); on s_req capture add/wen/wdata/be/id and sel = s_add[SEL_LSB +: clog2(NB_HWPE), min 1 bit].
REQ-015 IDLE, s_req, sel < NB_HWPE -> ISSUE; sel >= NB_HWPE -> ERR.
REQ-016 s_gnt = 0 in every state other than IDLE.
REQ-017 ISSUE: m_req[sel] = 1, other m_req bits 0, m_* fields driven from captured registers; on m_gnt[sel] -> WAIT_RSP.
REQ-018 m_add/m_wen/m_wdata/m_be/m_id hold captured values whenever not IDLE; 0 in IDLE.
REQ-019 WAIT_RSP: on m_r_valid[sel] capture m_r_rdata/m_r_opc/m_r_id slice sel -> RESP.
REQ-020 RESP: s_r_valid = 1 for exactly one cycle with captured data -> IDLE.
REQ-021 ERR: s_r_valid = 1 one cycle, s_r_opc = 1, s_r_rdata = ERR_RDATA (32'hBADACCE5), s_r_id = captured id; err_cnt += 1 (saturate 255) -> IDLE.
REQ-022 Timeout counter cleared on entry to ISSUE, increments each cycle in ISSUE/WAIT_RSP; reaching TIMEOUT -> ERR.
REQ-023 Simultaneous m_gnt/m_r_valid and timeout expiry: handshake wins, no ERR.
REQ-024 m_r_valid or m_gnt from non-selected targets, or outside WAIT_RSP/ISSUE respectively, ignored.
REQ-025 s_r_valid, s_r_opc, s_r_rdata, s_r_id are 0 outside RESP/ERR.
REQ-026 Latency, zero-wait target: accept c0, m_req c1 with m_gnt, m_r_valid c2, s_r_valid c3; next accept c4.

Reset
REQ-027 rst asserted (any state, mid-transaction included): state IDLE, all outputs 0, captured registers, timeout counter and err_cnt 0, asynchronously.
REQ-028 Transaction in flight at reset is dropped; late target responses after reset are ignored per REQ-024.

Structure
REQ-029 Package periph_acc_cfg_arb_pkg holds the FSM state enum and ERR_RDATA constant.
REQ-030 Single module, no sub-modules; state, capture, timeout and err_cnt registers in one async-reset process.

Verification
REQ-031 Write sel=1, add=0x0000_0404, wdata=0xA5A5_5A5A, m_gnt[1] c1, m_r_valid[1] c2 -> m_req=2'b10 c1, s_r_valid c3 with s_r_opc=0, id echoed.
REQ-032 Read sel=0, target gnt after 3 wait cycles, r_rdata=0x1234_5678 -> s_r_rdata=0x1234_5678, s_gnt low throughout, second s_req held until IDLE.
REQ-033 NB_HWPE=3, add sel=3 -> no m_req, ERR next cycle, s_r_rdata=0xBADACCE5, s_r_opc=1, err_cnt=1.
REQ-034 TIMEOUT=4, target never responds -> s_r_valid error response 5 cycles after accept; m_r_valid coincident with expiry -> normal response.
REQ-035 rst pulse during WAIT_RSP, then stale m_r_valid -> no s_r_valid, next transaction completes normally.
REQ-036 300 consecutive ERR transactions -> err_cnt saturates at 255.

Source files
------------

// File: rtl/periph_acc_cfg_arb_pkg.sv
// Shared types for the peripheral accelerator config arbiter.
// FSM state encoding and the error-response read data pattern.
package periph_acc_cfg_arb_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT_RSP,
      RESP,
      ERR
   } arb_state_e;

   localparam logic [31:0] ERR_RDATA = 32'hBADACCE5;

endpackage

// File: rtl/periph_acc_cfg_arbiter.sv
// Routes one speriph config transaction at a time to an HWPE target,
// with address decode, per-transaction timeout and error responses.
module periph_acc_cfg_arbiter
   import periph_acc_cfg_arb_pkg::*;
#(
   parameter int NB_HWPE  = 2,
   parameter int ID_WIDTH = 5,
   parameter int SEL_LSB  = 10,
   parameter int TIMEOUT  = 255
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         s_req,
   input  logic [31:0]                  s_add,
   input  logic                         s_wen,
   input  logic [31:0]                  s_wdata,
   input  logic [3:0]                   s_be,
   input  logic [ID_WIDTH-1:0]          s_id,
   output logic                         s_gnt,
   output logic                         s_r_valid,
   output logic [31:0]                  s_r_rdata,
   output logic                         s_r_opc,
   output logic [ID_WIDTH-1:0]          s_r_id,
   output logic [NB_HWPE-1:0]           m_req,
   output logic [31:0]                  m_add,
   output logic                         m_wen,
   output logic [31:0]                  m_wdata,
   output logic [3:0]                   m_be,
   output logic [ID_WIDTH-1:0]          m_id,
   input  logic [NB_HWPE-1:0]           m_gnt,
   input  logic [NB_HWPE-1:0]           m_r_valid,
   input  logic [NB_HWPE*32-1:0]        m_r_rdata,
   input  logic [NB_HWPE-1:0]           m_r_opc,
   input  logic [NB_HWPE*ID_WIDTH-1:0]  m_r_id,
   output logic [7:0]                   err_cnt
);

   localparam int SEL_W = (NB_HWPE > 1) ? $clog2(NB_HWPE) : 1;
   localparam logic [SEL_W:0] NB_L = (SEL_W + 1)'(NB_HWPE);
   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

   arb_state_e state;

   logic [31:0]         cap_add;
   logic                cap_wen;
   logic [31:0]         cap_wdata;
   logic [3:0]          cap_be;
   logic [ID_WIDTH-1:0] cap_id;
   logic [SEL_W-1:0]    sel;
   logic [31:0]         rsp_rdata;
   logic                rsp_opc;
   logic [ID_WIDTH-1:0] rsp_id;
   logic [15:0]         tmo_cnt;
   logic [7:0]          err_q;

   logic [SEL_W-1:0]    s_sel;
   logic                tgt_gnt;
   logic                tgt_valid;
   logic [31:0]         tgt_rdata;
   logic                tgt_opc;
   logic [ID_WIDTH-1:0] tgt_id;
   logic                tmo_hit;
   logic                busy;

   assign s_sel   = s_add[SEL_LSB +: SEL_W];
   assign tmo_hit = (tmo_cnt >= TMO_LAST);
   assign busy    = (state != IDLE);

   // Only the selected target's handshake and response are visible
   always_comb begin
      tgt_gnt   = 1'b0;
      tgt_valid = 1'b0;
      tgt_rdata = '0;
      tgt_opc   = 1'b0;
      tgt_id    = '0;
      for (int i = 0; i < NB_HWPE; i++) begin
         if (sel == SEL_W'(i)) begin
            tgt_gnt   = m_gnt[i];
            tgt_valid = m_r_valid[i];
            tgt_rdata = m_r_rdata[i*32 +: 32];
            tgt_opc   = m_r_opc[i];
            tgt_id    = m_r_id[i*ID_WIDTH +: ID_WIDTH];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cap_add   <= '0;
         cap_wen   <= 1'b0;
         cap_wdata <= '0;
         cap_be    <= '0;
         cap_id    <= '0;
         sel       <= '0;
         rsp_rdata <= '0;
         rsp_opc   <= 1'b0;
         rsp_id    <= '0;
         tmo_cnt   <= '0;
         err_q     <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (s_req) begin
                  cap_add   <= s_add;
                  cap_wen   <= s_wen;
                  cap_wdata <= s_wdata;
                  cap_be    <= s_be;
                  cap_id    <= s_id;
                  sel       <= s_sel;
                  tmo_cnt   <= '0;
                  state     <= ({1'b0, s_sel} < NB_L) ? ISSUE : ERR;
               end
            end
            ISSUE: begin
               tmo_cnt <= tmo_cnt + 16'd1;
               if (tgt_gnt)
                  state <= WAIT_RSP;
               else if (tmo_hit)
                  state <= ERR;
            end
            WAIT_RSP: begin
               tmo_cnt <= tmo_cnt + 16'd1;
               if (tgt_valid) begin
                  rsp_rdata <= tgt_rdata;
                  rsp_opc   <= tgt_opc;
                  rsp_id    <= tgt_id;
                  state     <= RESP;
               end else if (tmo_hit) begin
                  state <= ERR;
               end
            end
            RESP: begin
               state <= IDLE;
            end
            ERR: begin
               if (err_q != 8'hFF)
                  err_q <= err_q + 8'd1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      m_req = '0;
      for (int i = 0; i < NB_HWPE; i++)
         m_req[i] = (state == ISSUE) && (sel == SEL_W'(i));
   end

   assign s_gnt   = (state == IDLE) && s_req && !rst;
   assign m_add   = busy ? cap_add   : '0;
   assign m_wen   = busy ? cap_wen   : 1'b0;
   assign m_wdata = busy ? cap_wdata : '0;
   assign m_be    = busy ? cap_be    : '0;
   assign m_id    = busy ? cap_id    : '0;
   assign err_cnt = err_q;

   always_comb begin
      s_r_valid = 1'b0;
      s_r_rdata = '0;
      s_r_opc   = 1'b0;
      s_r_id    = '0;
      unique case (1'b1)
         (state == RESP): begin
            s_r_valid = 1'b1;
            s_r_rdata = rsp_rdata;
            s_r_opc   = rsp_opc;
            s_r_id    = rsp_id;
         end
         (state == ERR): begin
            s_r_valid = 1'b1;
            s_r_rdata = ERR_RDATA;
            s_r_opc   = 1'b1;
            s_r_id    = cap_id;
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_periph_acc_cfg_arbiter.sv
// Directed bench for the config arbiter: three targets, short timeout,
// expected responses queued at accept time and popped on s_r_valid.
module tb_periph_acc_cfg_arbiter;

   localparam int NB = 3;
   localparam int IDW = 5;

   logic           clk;
   logic           rst;
   logic           s_req;
   logic [31:0]    s_add;
   logic           s_wen;
   logic [31:0]    s_wdata;
   logic [3:0]     s_be;
   logic [IDW-1:0] s_id;
   logic           s_gnt;
   logic           s_r_valid;
   logic [31:0]    s_r_rdata;
   logic           s_r_opc;
   logic [IDW-1:0] s_r_id;
   logic [NB-1:0]  m_req;
   logic [31:0]    m_add;
   logic           m_wen;
   logic [31:0]    m_wdata;
   logic [3:0]     m_be;
   logic [IDW-1:0] m_id;
   logic [NB-1:0]  m_gnt;
   logic [NB-1:0]  m_r_valid;
   logic [NB*32-1:0]  m_r_rdata;
   logic [NB-1:0]     m_r_opc;
   logic [NB*IDW-1:0] m_r_id;
   logic [7:0]     err_cnt;

   typedef struct {
      logic [31:0]    rdata;
      logic           opc;
      logic [IDW-1:0] id;
   } exp_t;

   exp_t exp_q[$];
   int   n_chk = 0;
   int   n_pass = 0;

   periph_acc_cfg_arbiter #(
      .NB_HWPE (NB),
      .ID_WIDTH(IDW),
      .SEL_LSB (10),
      .TIMEOUT (4)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .s_req    (s_req),
      .s_add    (s_add),
      .s_wen    (s_wen),
      .s_wdata  (s_wdata),
      .s_be     (s_be),
      .s_id     (s_id),
      .s_gnt    (s_gnt),
      .s_r_valid(s_r_valid),
      .s_r_rdata(s_r_rdata),
      .s_r_opc  (s_r_opc),
      .s_r_id   (s_r_id),
      .m_req    (m_req),
      .m_add    (m_add),
      .m_wen    (m_wen),
      .m_wdata  (m_wdata),
      .m_be     (m_be),
      .m_id     (m_id),
      .m_gnt    (m_gnt),
      .m_r_valid(m_r_valid),
      .m_r_rdata(m_r_rdata),
      .m_r_opc  (m_r_opc),
      .m_r_id   (m_r_id),
      .err_cnt  (err_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic req(input logic [31:0] a, input logic w,
                      input logic [31:0] d, input logic [IDW-1:0] id);
      s_req   = 1'b1;
      s_add   = a;
      s_wen   = w;
      s_wdata = d;
      s_be    = 4'hF;
      s_id    = id;
   endtask

   task automatic rsp(input int t, input logic [31:0] d, input logic o,
                      input logic [IDW-1:0] id);
      m_r_valid    = '0;
      m_r_valid[t] = 1'b1;
      m_r_rdata[t*32 +: 32] = d;
      m_r_opc[t]   = o;
      m_r_id[t*IDW +: IDW] = id;
   endtask

   task automatic push(input logic [31:0] d, input logic o,
                       input logic [IDW-1:0] id);
      exp_t e;
      e.rdata = d;
      e.opc   = o;
      e.id    = id;
      exp_q.push_back(e);
   endtask

   task automatic pop_chk(input string tag);
      exp_t e;
      chk({tag, " valid"}, 32'(s_r_valid), 32'd1);
      if (exp_q.size() == 0) begin
         n_chk++;
         $error("FAIL %s observed=response expected=no_entry", tag);
      end else begin
         e = exp_q.pop_front();
         chk({tag, " rdata"}, s_r_rdata, e.rdata);
         chk({tag, " opc"}, 32'(s_r_opc), 32'(e.opc));
         chk({tag, " id"}, 32'(s_r_id), 32'(e.id));
      end
   endtask

   initial begin
      rst = 1'b1;
      s_req = 1'b1;
      s_add = '0;
      s_wen = 1'b0;
      s_wdata = '0;
      s_be = '0;
      s_id = '0;
      m_gnt = '0;
      m_r_valid = '0;
      m_r_rdata = '0;
      m_r_opc = '0;
      m_r_id = '0;
      #3;
      chk("rst s_gnt", 32'(s_gnt), 32'd0);
      chk("rst s_r_valid", 32'(s_r_valid), 32'd0);
      chk("rst m_req", 32'(m_req), 32'd0);
      chk("rst m_add", m_add, 32'd0);
      chk("rst err_cnt", 32'(err_cnt), 32'd0);
      s_req = 1'b0;
      tick();
      rst = 1'b0;

      // zero-wait write to target 1
      tick();
      req(32'h0000_0404, 1'b0, 32'hA5A5_5A5A, 5'd3);
      push(32'h0, 1'b0, 5'd3);
      #2;
      chk("t1 gnt", 32'(s_gnt), 32'd1);
      chk("t1 idle m_req", 32'(m_req), 32'd0);
      tick();
      s_req = 1'b0;
      m_gnt = 3'b010;
      #2;
      chk("t1 m_req", 32'(m_req), 32'b010);
      chk("t1 m_add", m_add, 32'h0000_0404);
      chk("t1 m_wdata", m_wdata, 32'hA5A5_5A5A);
      chk("t1 m_wen", 32'(m_wen), 32'd0);
      chk("t1 m_be", 32'(m_be), 32'hF);
      chk("t1 m_id", 32'(m_id), 32'd3);
      tick();
      m_gnt = '0;
      rsp(1, 32'h0, 1'b0, 5'd3);
      #2;
      chk("t1 c2 valid", 32'(s_r_valid), 32'd0);
      chk("t1 c2 m_req", 32'(m_req), 32'd0);
      tick();
      m_r_valid = '0;
      #2;
      pop_chk("t1");

      // read from target 0, grant after three wait cycles
      tick();
      req(32'h0000_0010, 1'b1, 32'h0, 5'd7);
      push(32'h1234_5678, 1'b0, 5'd7);
      #2;
      chk("t2 gnt", 32'(s_gnt), 32'd1);
      chk("t2 idle m_add", m_add, 32'd0);
      for (int k = 1; k <= 3; k++) begin
         tick();
         req(32'h0000_0C00, 1'b1, 32'h0, 5'd9);
         #2;
         chk("t2 wait gnt", 32'(s_gnt), 32'd0);
         chk("t2 wait m_req", 32'(m_req), 32'b001);
      end
      tick();
      m_gnt = 3'b001;
      #2;
      chk("t2 expiry gnt", 32'(s_gnt), 32'd0);
      chk("t2 expiry m_req", 32'(m_req), 32'b001);
      chk("t2 expiry valid", 32'(s_r_valid), 32'd0);
      tick();
      m_gnt = '0;
      rsp(0, 32'h1234_5678, 1'b0, 5'd7);
      #2;
      chk("t2 wait_rsp gnt", 32'(s_gnt), 32'd0);
      chk("t2 wait_rsp valid", 32'(s_r_valid), 32'd0);
      tick();
      m_r_valid = '0;
      #2;
      chk("t2 resp gnt", 32'(s_gnt), 32'd0);
      pop_chk("t2");

      // held request decodes to sel 3, which has no target
      tick();
      push(32'hBADA_CCE5, 1'b1, 5'd9);
      #2;
      chk("t3 gnt", 32'(s_gnt), 32'd1);
      tick();
      s_req = 1'b0;
      #2;
      chk("t3 m_req", 32'(m_req), 32'd0);
      pop_chk("t3");
      chk("t3 err_cnt pre", 32'(err_cnt), 32'd0);
      tick();
      #2;
      chk("t3 err_cnt", 32'(err_cnt), 32'd1);
      chk("t3 idle valid", 32'(s_r_valid), 32'd0);

      // target 2 never answers
      tick();
      req(32'h0000_0800, 1'b0, 32'h11, 5'd4);
      push(32'hBADA_CCE5, 1'b1, 5'd4);
      #2;
      chk("t4 gnt", 32'(s_gnt), 32'd1);
      for (int k = 1; k <= 4; k++) begin
         tick();
         s_req = 1'b0;
         #2;
         chk("t4 wait valid", 32'(s_r_valid), 32'd0);
         chk("t4 wait m_req", 32'(m_req), 32'b100);
      end
      tick();
      #2;
      pop_chk("t4");
      tick();
      #2;
      chk("t4 err_cnt", 32'(err_cnt), 32'd2);

      // response coincident with timeout expiry, stray traffic ignored
      tick();
      req(32'h0000_0400, 1'b1, 32'h0, 5'd5);
      push(32'hCAFE_0001, 1'b0, 5'd5);
      #2;
      tick();
      s_req = 1'b0;
      m_gnt = 3'b010;
      #2;
      chk("t5 m_req", 32'(m_req), 32'b010);
      tick();
      m_gnt = '0;
      rsp(0, 32'hDEAD_0000, 1'b1, 5'd5);
      #2;
      chk("t5 stray rsp", 32'(s_r_valid), 32'd0);
      tick();
      m_r_valid = '0;
      m_gnt = 3'b001;
      #2;
      chk("t5 stray gnt", 32'(s_r_valid), 32'd0);
      tick();
      m_gnt = '0;
      rsp(1, 32'hCAFE_0001, 1'b0, 5'd5);
      #2;
      chk("t5 expiry valid", 32'(s_r_valid), 32'd0);
      tick();
      m_r_valid = '0;
      #2;
      pop_chk("t5");
      chk("t5 err_cnt", 32'(err_cnt), 32'd2);

      // reset during WAIT_RSP, then a stale response
      tick();
      req(32'h0000_0000, 1'b0, 32'h77, 5'd6);
      #2;
      tick();
      s_req = 1'b0;
      m_gnt = 3'b001;
      #2;
      tick();
      m_gnt = '0;
      #2;
      rst = 1'b1;
      #1;
      chk("t6 rst valid", 32'(s_r_valid), 32'd0);
      chk("t6 rst m_add", m_add, 32'd0);
      chk("t6 rst m_id", 32'(m_id), 32'd0);
      chk("t6 rst m_req", 32'(m_req), 32'd0);
      chk("t6 rst err_cnt", 32'(err_cnt), 32'd0);
      tick();
      rst = 1'b0;
      rsp(0, 32'h66, 1'b0, 5'd6);
      #2;
      chk("t6 stale valid", 32'(s_r_valid), 32'd0);
      tick();
      #2;
      chk("t6 stale valid2", 32'(s_r_valid), 32'd0);
      tick();
      m_r_valid = '0;
      #2;
      chk("t6 stale valid3", 32'(s_r_valid), 32'd0);
      tick();
      req(32'h0000_0404, 1'b1, 32'h0, 5'd1);
      push(32'h55AA_55AA, 1'b1, 5'd1);
      #2;
      chk("t6 gnt", 32'(s_gnt), 32'd1);
      tick();
      s_req = 1'b0;
      m_gnt = 3'b010;
      #2;
      chk("t6 m_req", 32'(m_req), 32'b010);
      tick();
      m_gnt = '0;
      rsp(1, 32'h55AA_55AA, 1'b1, 5'd1);
      #2;
      tick();
      m_r_valid = '0;
      #2;
      pop_chk("t6");

      // error counter saturation
      for (int n = 0; n < 300; n++) begin
         tick();
         req(32'h0000_0C00, 1'b1, 32'h0, n[4:0]);
         push(32'hBADA_CCE5, 1'b1, n[4:0]);
         #2;
         if (n == 254 || n == 255)
            chk("t7 err_cnt mid", 32'(err_cnt), 32'(n));
         tick();
         s_req = 1'b0;
         #2;
         pop_chk("t7");
      end
      tick();
      #2;
      chk("t7 err_cnt sat", 32'(err_cnt), 32'd255);
      chk("t7 queue empty", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
